// File: rtl/hidden_cpu_pkg.sv
// hidden_cpu_pkg
//   Shared definitions for the hidden_cpu_gen2 core: opcode and
//   branch-condition encodings, the output-select state type and the
//   instruction field-slice helper.
//   Instruction word layout: {opcode[1:0], rd[AW-1:0], rs[AW-1:0]}.
package hidden_cpu_pkg;

    // Widest register-address field the helper can slice (NREG <= 256).
    localparam int unsigned MAX_AW = 8;
    localparam int unsigned MAX_IW = 2 + 2 * MAX_AW;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_MOV = 2'b11;

    // Branch conditions live in the rs field of a BR instruction.
    localparam logic [MAX_AW-1:0] BC_CARRY  = MAX_AW'(0);
    localparam logic [MAX_AW-1:0] BC_BORROW = MAX_AW'(1);
    localparam logic [MAX_AW-1:0] BC_UNCOND = MAX_AW'(2);
    localparam logic [MAX_AW-1:0] BC_TOGGLE = MAX_AW'(3);

    typedef enum logic {
        SEL_PC  = 1'b0,
        SEL_OFS = 1'b1
    } out_sel_e;

    // Extract `width` bits starting at `lsb` from a zero-extended
    // instruction word; the result is zero-extended to MAX_AW bits.
    function automatic logic [MAX_AW-1:0] instr_field(
        input logic [MAX_IW-1:0] word,
        input int unsigned       lsb,
        input int unsigned       width
    );
        logic [MAX_AW-1:0] f;
        f = '0;
        for (int unsigned i = 0; i < MAX_AW; i++) begin
            if (i < width) f[i] = word[lsb + i];
        end
        return f;
    endfunction

endpackage

// File: rtl/hidden_cpu_alu.sv
// hidden_cpu_alu
//   Combinational ALU for hidden_cpu_gen2.
//   Ports:
//     op         in  2       opcode
//     a, b       in  DATA_W  operands R[rd], R[rs]
//     result     out DATA_W  value to write into R[rd]
//     carry_out  out 1       ADD carry (or MUL high-half non-zero)
//     borrow_out out 1       SUB borrow (a < b, unsigned)
//     wr_en      out 1       result must be written to R[rd]
//   Macro HIDDENCPU_MUL_EN: opcode 11 becomes MUL instead of MOV.
module hidden_cpu_alu
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              borrow_out,
    output logic              wr_en
);

`ifdef HIDDENCPU_MUL_EN
    logic [2*DATA_W-1:0] product;
    assign product = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

    always_comb begin
        result     = '0;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        wr_en      = 1'b0;
        case (op)
            OP_ADD: begin
                {carry_out, result} = {1'b0, a} + {1'b0, b};
                wr_en = 1'b1;
            end
            OP_SUB: begin
                result     = a - b;
                borrow_out = (a < b);
                wr_en      = 1'b1;
            end
            OP_MOV: begin
`ifdef HIDDENCPU_MUL_EN
                result    = product[DATA_W-1:0];
                carry_out = |product[2*DATA_W-1:DATA_W];
`else
                result    = b;
`endif
                wr_en = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/hidden_cpu_gen2.sv
// hidden_cpu_gen2
//   Pin-fed CPU core: one instruction per valid beat, 2-stage
//   latch/execute pipeline over an NREG x DATA_W register file with
//   registered carry/borrow flags and relative branches (offset in
//   R[NREG-1]).
//   Ports:
//     clk         in  1                  system clock
//     rst         in  1                  synchronous active-high reset
//     instr_valid in  1                  instr holds a new instruction
//     instr       in  2+2*AW             {opcode, rd, rs}
//     out         out max(PC_W,DATA_W)   PC (out_sel=0) or R[NREG-1]
//     out_sel     out 1                  output-select state
//     carry       out 1                  carry flag
//     borrow      out 1                  borrow flag
//   Macro HIDDENCPU_MUL_EN: opcode 11 executes MUL instead of MOV.
module hidden_cpu_gen2
    import hidden_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    parameter int PC_W   = 8,
    parameter int AW     = $clog2(NREG)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         instr_valid,
    input  logic [2+2*AW-1:0]                            instr,
    output logic [((PC_W > DATA_W) ? PC_W : DATA_W)-1:0] out,
    output logic                                         out_sel,
    output logic                                         carry,
    output logic                                         borrow
);

    localparam int IW    = 2 + 2 * AW;
    localparam int OUT_W = (PC_W > DATA_W) ? PC_W : DATA_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [PC_W-1:0]   pc;
    out_sel_e          sel;
    logic              s1_valid;
    logic [IW-1:0]     s1_instr;

    logic [MAX_IW-1:0] s1_word;
    logic [1:0]        op;
    logic [AW-1:0]     rd;
    logic [MAX_AW-1:0] rs_full;
    logic [AW-1:0]     rs;

    assign s1_word = MAX_IW'(s1_instr);
    assign op      = 2'(instr_field(s1_word, 2 * AW, 2));
    assign rd      = AW'(instr_field(s1_word, AW, AW));
    assign rs_full = instr_field(s1_word, 0, AW);
    assign rs      = AW'(rs_full);

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_borrow;
    logic              alu_wr_en;

    hidden_cpu_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op         (op),
        .a          (regs[rd]),
        .b          (regs[rs]),
        .result     (alu_result),
        .carry_out  (alu_carry),
        .borrow_out (alu_borrow),
        .wr_en      (alu_wr_en)
    );

    logic [PC_W-1:0] pc_next;
    out_sel_e        sel_next;

    always_comb begin
        pc_next  = pc + PC_W'(1);
        sel_next = sel;
        if (op == OP_BR) begin
            // rs is compared zero-extended so narrow AW never aliases
            // onto a branch condition it cannot encode.
            case (rs_full)
                BC_CARRY:  if (carry)  pc_next = pc + PC_W'(regs[NREG-1]);
                BC_BORROW: if (borrow) pc_next = pc + PC_W'(regs[NREG-1]);
                BC_UNCOND: pc_next = pc + PC_W'(regs[NREG-1]);
                BC_TOGGLE: sel_next = (sel == SEL_PC) ? SEL_OFS : SEL_PC;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
            carry    <= 1'b0;
            borrow   <= 1'b0;
            sel      <= SEL_PC;
            s1_valid <= 1'b0;
            s1_instr <= '0;
        end else begin
            s1_valid <= instr_valid;
            s1_instr <= instr;
            if (s1_valid) begin
                pc  <= pc_next;
                sel <= sel_next;
                if (alu_wr_en) regs[rd] <= alu_result;
                if (op == OP_ADD) carry <= alu_carry;
`ifdef HIDDENCPU_MUL_EN
                if (op == OP_MOV) carry <= alu_carry;
`endif
                if (op == OP_SUB) borrow <= alu_borrow;
            end
        end
    end

    assign out_sel = (sel == SEL_OFS);
    assign out     = (sel == SEL_OFS) ? OUT_W'(regs[NREG-1]) : OUT_W'(pc);

endmodule
